// File: rtl/dma_read_fetcher.sv
// DMA read fetcher: issues AXI4 INCR read bursts for a byte range and packs
// the 32-bit read beats into 128-bit blocks for the downstream crypto engine.
module dma_read_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_src_addr,
  input  logic [31:0]               i_total_len,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [4*DATA_WIDTH-1:0]   o_blk_data,
  output logic                      o_blk_valid,
  input  logic                      i_blk_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [29:0]               words_q;
  logic [4:0]                beats_q;
  logic [3*DATA_WIDTH-1:0]   pack_q;
  logic [1:0]                idx_q;
  logic                      err_q;
  logic                      error_q;
  logic [4*DATA_WIDTH-1:0]   blk_data_q;
  logic                      blk_valid_q;

  logic [4:0]                burst_beats;
  logic [10:0]               to_bnd;
  logic                      start_ok;
  logic                      start_bad;
  logic                      ar_hs;
  logic                      r_hs;
  logic                      beat_err;
  logic                      stall;
  logic                      pack_en;

  assign start_ok  = (state_q == S_IDLE) && i_start;
  assign start_bad = (i_total_len == 32'd0) || (i_total_len[3:0] != 4'd0) ||
                     (i_src_addr[1:0] != 2'd0);
  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  // rlast must coincide exactly with the final expected beat of the burst
  assign beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rlast != (beats_q == 5'd1));
  // once errored, blocks are dropped so there is no reason to back-pressure
  assign stall     = (idx_q == 2'd3) && blk_valid_q && !i_blk_ready && !err_q;
  assign pack_en   = r_hs && !err_q && !beat_err;
  assign to_bnd    = 11'd1024 - {1'b0, addr_q[11:2]};

  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign o_blk_data    = blk_data_q;
  assign o_blk_valid   = blk_valid_q;
  assign o_error       = error_q;

  // burst length: min(remaining words, MAX_BURST, words to next 4 KB page)
  always_comb begin
    burst_beats = 5'(MAX_BURST);
    if (words_q < 30'(MAX_BURST))
      burst_beats = words_q[4:0];
    if (to_bnd < {6'd0, burst_beats})
      burst_beats = to_bnd[4:0];
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // next-state and handshake outputs
  always_comb begin
    state_d       = state_q;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    o_done        = 1'b0;
    o_busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_start)
          state_d = start_bad ? S_ERR : S_AR;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready)
          state_d = S_R;
      end
      S_R: begin
        m_axi_rready = !stall;
        if (r_hs && m_axi_rlast) begin
          if (err_q || beat_err)
            state_d = S_ERR;
          else if (words_q != 30'd0)
            state_d = S_AR;
          else
            state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!blk_valid_q || i_blk_ready)
          state_d = S_DONE;
      end
      S_ERR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    m_axi_araddr = m_axi_arvalid ? addr_q : '0;
    m_axi_arlen  = m_axi_arvalid ? {3'd0, burst_beats - 5'd1} : '0;
  end

  // transfer bookkeeping, beat packing and the block output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      words_q     <= '0;
      beats_q     <= '0;
      pack_q      <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      error_q     <= 1'b0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q  <= i_src_addr;
        words_q <= i_total_len[31:2];
        idx_q   <= '0;
        err_q   <= 1'b0;
        error_q <= 1'b0;
      end
      if (ar_hs) begin
        addr_q  <= addr_q + {{(ADDR_WIDTH-7){1'b0}}, burst_beats, 2'b00};
        words_q <= words_q - {25'd0, burst_beats};
        beats_q <= burst_beats;
      end
      if (r_hs) begin
        if (beat_err)
          err_q <= 1'b1;
        if (beats_q != 5'd0)
          beats_q <= beats_q - 5'd1;
      end
      if (pack_en) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    pack_q[DATA_WIDTH-1:0]              <= m_axi_rdata;
          2'd1:    pack_q[2*DATA_WIDTH-1:DATA_WIDTH]   <= m_axi_rdata;
          2'd2:    pack_q[3*DATA_WIDTH-1:2*DATA_WIDTH] <= m_axi_rdata;
          default: blk_data_q <= {m_axi_rdata, pack_q};
        endcase
      end
      // a new block may load in the same cycle the previous one is taken
      if (pack_en && (idx_q == 2'd3))
        blk_valid_q <= 1'b1;
      else if (i_blk_ready)
        blk_valid_q <= 1'b0;
      if (state_q == S_ERR)
        error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_read_fetcher.sv
// Testbench for dma_read_fetcher: table of transfers driven against a
// cycle-level AXI read slave, with AR/block scoreboards and directed reset test.
module tb_dma_read_fetcher;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [31:0]   i_src_addr;
  logic [31:0]   i_total_len;
  logic          o_busy, o_done, o_error;
  logic [31:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [127:0]  o_blk_data;
  logic          o_blk_valid, i_blk_ready;

  dma_read_fetcher #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_src_addr(i_src_addr), .i_total_len(i_total_len),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .o_blk_data(o_blk_data), .o_blk_valid(o_blk_valid), .i_blk_ready(i_blk_ready)
  );

  always #5 clk = ~clk;

  localparam int NONE = 255;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          ar_delay;
    int          stall;
    int          err_beat;
    int          early_beat;
    int          mid_start;
    int          exp_nar;
    int          exp_nblk;
    int          exp_arlen;
    int          exp_drop;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t          exp_ar[$];
  logic [127:0] exp_blk[$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] len,
                              input int ar_delay, input int stall, input int err_beat,
                              input int early_beat, input int mid_start, input int nar,
                              input int nblk, input int arlen, input int drop,
                              input int lat, input logic err);
    vec_t v;
    v.addr = addr; v.len = len; v.ar_delay = ar_delay; v.stall = stall;
    v.err_beat = err_beat; v.early_beat = early_beat; v.mid_start = mid_start;
    v.exp_nar = nar; v.exp_nblk = nblk; v.exp_arlen = arlen; v.exp_drop = drop;
    v.exp_lat = lat; v.exp_err = err;
    return v;
  endfunction

  // reference model: expected AR sequence and blocks for one transfer
  task automatic model_push(input vec_t v);
    logic [31:0] a;
    int w, b, bnd, nblk, cut;
    ar_t r;
    if (v.len == 0 || v.len[3:0] != 0 || v.addr[1:0] != 0) return;
    cut = (v.err_beat < v.early_beat) ? v.err_beat : v.early_beat;
    a = v.addr;
    w = int'(v.len / 4);
    while (w > 0) begin
      bnd = (4096 - int'(a % 4096)) / 4;
      b = (w < 16) ? w : 16;
      if (bnd < b) b = bnd;
      r.addr = a; r.len = 8'(b - 1);
      exp_ar.push_back(r);
      a = a + 32'(b * 4);
      w = w - b;
      if (cut != NONE) w = 0;
    end
    nblk = (cut != NONE) ? cut / 4 : int'(v.len / 16);
    for (int k = 0; k < nblk; k++) begin
      a = v.addr + 32'(16 * k);
      exp_blk.push_back({word_at(a + 12), word_at(a + 8), word_at(a + 4), word_at(a)});
    end
  endtask

  task automatic idle_inputs();
    i_start = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
    m_axi_rresp = 0; m_axi_rdata = 0; i_blk_ready = 1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc = 0, nar = 0, nblk = 0, beat = 0, r_left = 0, ar_wait = 0;
    int stall_left = 0, drop = NONE, first_arlen = -1;
    logic stall_used = 0, prev_pend = 0, done = 0;
    logic [31:0] r_addr = 0, prev_addr = 0;
    logic [7:0] prev_len = 0;
    ar_t e;
    string tag;
    tag = $sformatf("v%0d", id);
    model_push(v);
    @(negedge clk);
    idle_inputs();
    i_src_addr = v.addr; i_total_len = v.len; i_start = 1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (v.mid_start != 0 && cyc == 5) begin
        i_start = 1; i_src_addr = 32'hDEAD0000; i_total_len = 32'h40;
      end else i_start = 0;
      done = o_done;
      if (o_blk_valid && !stall_used && v.stall > 0) begin
        stall_left = v.stall; stall_used = 1;
      end
      i_blk_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      ar_wait = m_axi_arvalid ? ar_wait + 1 : 0;
      m_axi_arready = (ar_wait > v.ar_delay);
      if (prev_pend)
        chk({tag, "_ar_stable"}, {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, prev_addr, prev_len});
      if (r_left > 0) begin
        m_axi_rvalid = 1; m_axi_rdata = word_at(r_addr);
        m_axi_rresp = (beat == v.err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast = (r_left == 1) || (beat == v.early_beat);
      end else begin
        m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
      end
      #1;
      if (m_axi_rvalid && !m_axi_rready && drop == NONE) drop = beat;
      if (m_axi_rvalid && m_axi_rready) begin
        r_left = m_axi_rlast ? 0 : r_left - 1;
        r_addr += 4; beat++;
      end
      if (o_blk_valid && i_blk_ready) begin
        nblk++;
        if (exp_blk.size() == 0) chk({tag, "_blk_extra"}, o_blk_data, 128'd0);
        else chk({tag, "_blk_data"}, o_blk_data, exp_blk.pop_front());
      end
      if (m_axi_arvalid && m_axi_arready) begin
        chk({tag, "_ar_outstanding"}, 128'(r_left), 128'd0);
        chk({tag, "_ar_size_burst"}, {m_axi_arsize, m_axi_arburst}, {3'b010, 2'b01});
        if (exp_ar.size() == 0) chk({tag, "_ar_extra"}, {m_axi_araddr, m_axi_arlen}, 0);
        else begin
          e = exp_ar.pop_front();
          chk({tag, "_ar_addr_len"}, {m_axi_araddr, m_axi_arlen}, {e.addr, e.len});
        end
        if (nar == 0) first_arlen = int'(m_axi_arlen);
        nar++;
        r_addr = m_axi_araddr; r_left = int'(m_axi_arlen) + 1; beat = beat;
        prev_pend = 0;
      end else begin
        prev_pend = m_axi_arvalid; prev_addr = m_axi_araddr; prev_len = m_axi_arlen;
      end
      if (cyc > 2000) begin
        chk({tag, "_done_timeout"}, 128'(cyc), 128'd0);
        done = 1;
      end
    end
    chk({tag, "_error"}, 128'(o_error), 128'(v.exp_err));
    chk({tag, "_nar"}, 128'(nar), 128'(v.exp_nar));
    chk({tag, "_nblk"}, 128'(nblk), 128'(v.exp_nblk));
    chk({tag, "_drop_beat"}, 128'(drop), 128'(v.exp_drop));
    chk({tag, "_queues_left"}, 128'(exp_ar.size() + exp_blk.size()), 128'd0);
    if (v.exp_nar > 0) chk({tag, "_first_arlen"}, 128'(first_arlen), 128'(v.exp_arlen));
    if (v.exp_lat > 0) chk({tag, "_done_latency"}, 128'(cyc), 128'(v.exp_lat));
    idle_inputs();
    @(negedge clk);
    chk({tag, "_after_done"}, {o_done, o_busy, o_error}, {1'b0, 1'b0, v.exp_err});
    exp_ar.delete(); exp_blk.delete();
  endtask

  vec_t vecs[11];
  vec_t clean;
  int   bad;

  initial begin
    vecs[0]  = mk(32'h1000, 64,  0, 0,  NONE, NONE, 0, 1, 4, 15, NONE, 0, 1'b0);
    vecs[1]  = mk(32'h0FF0, 32,  0, 0,  NONE, NONE, 0, 2, 2, 3,  NONE, 0, 1'b0);
    vecs[2]  = mk(32'h2000, 64,  0, 10, NONE, NONE, 0, 1, 4, 15, 7,    0, 1'b0);
    vecs[3]  = mk(32'h3000, 64,  0, 0,  5,    NONE, 0, 1, 1, 15, NONE, 0, 1'b1);
    vecs[4]  = mk(32'h4000, 24,  0, 0,  NONE, NONE, 0, 0, 0, 0,  NONE, 2, 1'b1);
    vecs[5]  = mk(32'h1002, 32,  0, 0,  NONE, NONE, 0, 0, 0, 0,  NONE, 2, 1'b1);
    vecs[6]  = mk(32'h4000, 0,   0, 0,  NONE, NONE, 0, 0, 0, 0,  NONE, 2, 1'b1);
    vecs[7]  = mk(32'h0FF8, 160, 3, 0,  NONE, NONE, 0, 4, 10, 1, NONE, 0, 1'b0);
    vecs[8]  = mk(32'h5000, 16,  0, 0,  NONE, NONE, 1, 1, 1, 3,  NONE, 0, 1'b0);
    vecs[9]  = mk(32'h7FC0, 128, 0, 0,  NONE, NONE, 0, 2, 8, 15, NONE, 0, 1'b0);
    vecs[10] = mk(32'h9000, 64,  0, 0,  NONE, 9,    0, 1, 2, 15, NONE, 0, 1'b1);
    clean    = mk(32'h6000, 64,  0, 0,  NONE, NONE, 0, 1, 4, 15, NONE, 0, 1'b0);

    rst = 1; i_src_addr = 0; i_total_len = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {o_busy, o_done, o_error, m_axi_arvalid, m_axi_rready, o_blk_valid}, 0);
    chk("reset_data", {o_blk_data, m_axi_araddr, m_axi_arlen}, 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // reset asserted in the middle of a burst
    @(negedge clk);
    i_src_addr = 32'h6000; i_total_len = 64; i_start = 1;
    m_axi_arready = 1; m_axi_rvalid = 1; m_axi_rdata = 32'hCAFE0000;
    @(negedge clk);
    i_start = 0;
    repeat (6) @(negedge clk);
    chk("midburst_busy", {o_busy, m_axi_rready}, 2'b11);
    rst = 1;
    #1;
    chk("midrst_ctrl", {o_busy, o_done, o_error, m_axi_arvalid, m_axi_rready, o_blk_valid}, 0);
    chk("midrst_data", {o_blk_data, m_axi_araddr, m_axi_arlen}, 0);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_busy || m_axi_arvalid) bad++;
    end
    chk("no_resume", 128'(bad), 128'd0);
    run_vec(clean, 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
